async_fire_scheduler: RTL and testbench

- Sequencer for speed-independent circuit models that expose one "active" gate-select input, such as the N-bit async counter with 3*N gates.
- Each firing slot, the block picks exactly one currently excited gate and drives its index on active for one cycle. It uses a round-robin or LFSR-random interleaving policy.
- It counts firings, enforces an optional step limit, and flags deadlock.
- It sits between the testbench/formal harness and the modelled async datapath.

---
 rtl/async_fire_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_async_fire_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fire_scheduler.sv
// async_fire_scheduler: picks one excited gate per firing slot and presents
// its index on `active` for exactly one FIRE cycle. Interleaving is either
// round-robin from the last fired gate (mode=0) or a circular search that
// starts at an LFSR-derived index (mode=1). The block counts firings, stops
// at an optional step limit, and reports deadlock.
//
// Build option: define ASYNC_SCHED_STARVE_MON_EN to build per-gate age
// counters and the sticky starved/starved_idx outputs.
//
// state | meaning
// IDLE  | waiting for enable, active=G
// PICK  | sample excited, choose next gate (or detect deadlock)
// FIRE  | drive chosen gate on active for one cycle, fire=1
// DEAD  | no gate was excited while running, deadlock=1
// DONE  | step limit reached, done=1
module async_fire_scheduler #(
  parameter int          G      = 30,
  parameter int          IW     = 6,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          STARVE = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mode,
  input  logic [G-1:0]  excited,
  input  logic [15:0]   step_limit,
  output logic [IW-1:0] active,
  output logic          fire,
  output logic          deadlock,
  output logic          done,
  output logic [31:0]   step_count
`ifdef ASYNC_SCHED_STARVE_MON_EN
  ,
  output logic          starved,
  output logic [IW-1:0] starved_idx
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PICK = 3'd1;
  localparam logic [2:0] FIRE = 3'd2;
  localparam logic [2:0] DEAD = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [IW-1:0] G_I = IW'(G);
  localparam logic [IW:0]   G_W = (IW+1)'(G);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [IW-1:0] active_q, active_d;
  logic          fire_q, deadlock_q, done_q;

  logic [IW-1:0] start;
  logic [IW-1:0] choice;
  logic          found;
  logic [IW:0]   idx;
  logic [15:0]   lfsr_nxt;

  // Galois LFSR for x^16+x^14+x^13+x^11+1 (taps mask 0xB400).
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_nxt = lfsr_nxt ^ 16'hB400;
  end

  // Circular first-excited search starting at ptr (mode 0) or the folded LFSR value (mode 1).
  always_comb begin
    start = ptr_q;
    if (mode) start = (lfsr_q[IW-1:0] < G_I) ? lfsr_q[IW-1:0] : lfsr_q[IW-1:0] - G_I;
    found  = 1'b0;
    choice = G_I;
    idx    = '0;
    for (int k = 0; k < G; k++) begin
      idx = {1'b0, start} + (IW+1)'(k);
      if (idx >= G_W) idx = idx - G_W;
      if (!found && excited[idx[IW-1:0]]) begin
        found  = 1'b1;
        choice = idx[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (enable) state_d = PICK;
      PICK: begin
        lfsr_d = lfsr_nxt;
        if (!enable)    state_d = IDLE;
        else if (found) state_d = FIRE;
        else            state_d = DEAD;
      end
      FIRE: begin
        cnt_d = cnt_q + 32'd1;
        ptr_d = (active_q == G_I - IW'(1)) ? '0 : active_q + IW'(1);
        if (step_limit != 16'd0 && cnt_d[15:0] == step_limit) state_d = DONE;
        else if (enable)                                      state_d = PICK;
        else                                                  state_d = IDLE;
      end
      DEAD: if (!enable) state_d = IDLE;
      DONE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_d = (state_d == FIRE) ? choice : G_I;
  end

  // State and registered outputs; async reset pulls active back to G mid-firing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      active_q   <= G_I;
      fire_q     <= 1'b0;
      deadlock_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      fire_q     <= (state_d == FIRE);
      deadlock_q <= (state_d == DEAD);
      done_q     <= (state_d == DONE);
    end
  end

  assign active     = active_q;
  assign fire       = fire_q;
  assign deadlock   = deadlock_q;
  assign done       = done_q;
  assign step_count = cnt_q;

`ifdef ASYNC_SCHED_STARVE_MON_EN
  localparam int AW = $clog2(STARVE) + 1;
  localparam logic [AW-1:0] STARVE_A = AW'(STARVE);

  logic [AW-1:0] age_q [G];
  logic          starved_q, hit;
  logic [IW-1:0] starved_idx_q, hit_idx;

  // Age counters saturate at STARVE so the sticky flag can never be missed by wrap-around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < G; i++) age_q[i] <= '0;
    end else if (state_q == PICK) begin
      for (int i = 0; i < G; i++) begin
        if (excited[i] && !(found && choice == IW'(i)))
          age_q[i] <= (age_q[i] == STARVE_A) ? age_q[i] : age_q[i] + AW'(1);
        else
          age_q[i] <= '0;
      end
    end
  end

  // Lowest index whose age has reached the threshold.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = G - 1; i >= 0; i--) begin
      if (age_q[i] == STARVE_A) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Sticky capture of the first starvation event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starved_q     <= 1'b0;
      starved_idx_q <= '0;
    end else if (!starved_q && hit) begin
      starved_q     <= 1'b1;
      starved_idx_q <= hit_idx;
    end
  end

  assign starved     = starved_q;
  assign starved_idx = starved_idx_q;
`endif

endmodule

// File: tb/tb_async_fire_scheduler.sv
// Scoreboard bench for async_fire_scheduler: expected gate indices are
// queued when a scenario is set up and popped as fire pulses appear.
module tb_async_fire_scheduler;

  localparam int G  = 30;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic [G-1:0]  excited;
  logic [15:0]   step_limit;
  logic [IW-1:0] active;
  logic          fire;
  logic          deadlock;
  logic          done;
  logic [31:0]   step_count;
`ifdef ASYNC_SCHED_STARVE_MON_EN
  logic          starved;
  logic [IW-1:0] starved_idx;
`endif

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  int exp_q[$];
  int obs_q[$];
  int cyc_q[$];

  async_fire_scheduler #(.G(G), .IW(IW), .SEED(16'hACE1), .STARVE(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .excited    (excited),
    .step_limit (step_limit),
    .active     (active),
    .fire       (fire),
    .deadlock   (deadlock),
    .done       (done),
    .step_count (step_count)
`ifdef ASYNC_SCHED_STARVE_MON_EN
    ,
    .starved    (starved),
    .starved_idx(starved_idx)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Reset is released at a falling edge; the next posedge is cycle 1 after release.
  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic collect(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (fire) begin
        obs_q.push_back(int'(active));
        cyc_q.push_back(cycle);
        got++;
      end
    end
  endtask

  task automatic test_reset();
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (active !== 6'd30) begin failures++; $display("FAIL reset_active got=%0d exp=30", active); end
    checks++; if (fire !== 1'b0) begin failures++; $display("FAIL reset_fire got=%b exp=0", fire); end
    checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL reset_deadlock got=%b exp=0", deadlock); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (step_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", step_count); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (fire !== 1'b0) begin failures++; $display("FAIL first_fire_c1 got=%b exp=0", fire); end
    @(negedge clk);
    checks++; if (fire !== 1'b1 || active !== 6'd0) begin failures++; $display("FAIL first_fire_c2 fire=%b active=%0d exp fire=1 active=0", fire, active); end
  endtask

  task automatic test_round_robin();
    int got;
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd0;
    apply_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(i % G);
    collect(32, 100, got);
    checks++; if (got != 32) begin failures++; $display("FAIL rr_count_fires got=%0d exp=32", got); end
    for (int i = 1; i < cyc_q.size(); i++) begin
      checks++;
      if (cyc_q[i] - cyc_q[i-1] != 2) begin failures++; $display("FAIL rr_gap idx=%0d got=%0d exp=2", i, cyc_q[i] - cyc_q[i-1]); end
    end
    while (exp_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rr_seq missing exp=%0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o != e) begin failures++; $display("FAIL rr_seq got=%0d exp=%0d", o, e); end
      end
    end
    @(negedge clk);
    checks++; if (step_count !== 32'd32) begin failures++; $display("FAIL rr_step_count got=%0d exp=32", step_count); end
  endtask

  task automatic test_sparse();
    int got;
    enable = 1'b1; mode = 1'b0; step_limit = 16'd0;
    excited = '0; excited[3] = 1'b1; excited[17] = 1'b1;
    apply_reset();
    exp_q.push_back(3); exp_q.push_back(17); exp_q.push_back(3); exp_q.push_back(17);
    collect(4, 40, got);
    excited = '0; excited[29] = 1'b1;
    exp_q.push_back(29); exp_q.push_back(29); exp_q.push_back(29);
    collect(3, 40, got);
    excited[0] = 1'b1;
    exp_q.push_back(0);
    collect(1, 40, got);
    while (exp_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL sparse_seq missing exp=%0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o != e) begin failures++; $display("FAIL sparse_seq got=%0d exp=%0d", o, e); end
      end
    end
  endtask

  task automatic test_deadlock();
    bit seen_fire;
    enable = 1'b1; mode = 1'b0; excited = '0; step_limit = 16'd0;
    apply_reset();
    @(negedge clk);
    checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL dead_early got=%b exp=0", deadlock); end
    @(negedge clk);
    checks++; if (deadlock !== 1'b1) begin failures++; $display("FAIL dead_assert got=%b exp=1", deadlock); end
    seen_fire = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fire) seen_fire = 1'b1;
    end
    checks++; if (deadlock !== 1'b1 || active !== 6'd30) begin failures++; $display("FAIL dead_hold deadlock=%b active=%0d exp 1/30", deadlock, active); end
    checks++; if (seen_fire) begin failures++; $display("FAIL dead_fire got=1 exp=0"); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (deadlock !== 1'b0) begin failures++; $display("FAIL dead_clear got=%b exp=0", deadlock); end
  endtask

  task automatic test_step_limit();
    int got;
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd5;
    apply_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    collect(6, 40, got);
    checks++; if (got != 5) begin failures++; $display("FAIL limit_fires got=%0d exp=5", got); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL limit_done got=%b exp=1", done); end
    checks++; if (step_count !== 32'd5) begin failures++; $display("FAIL limit_count got=%0d exp=5", step_count); end
    while (exp_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL limit_seq missing exp=%0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o != e) begin failures++; $display("FAIL limit_seq got=%0d exp=%0d", o, e); end
      end
    end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || step_count !== 32'd5) begin failures++; $display("FAIL limit_release done=%b count=%0d exp 0/5", done, step_count); end
    step_limit = 16'd0;
  endtask

  task automatic test_abort();
    int got;
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd0;
    apply_reset();
    collect(1, 20, got);
    checks++; if (got != 1) begin failures++; $display("FAIL abort_first got=%0d exp=1", got); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (fire !== 1'b0 || active !== 6'd30 || step_count !== 32'd1) begin failures++; $display("FAIL abort_fire fire=%b active=%0d count=%0d exp 0/30/1", fire, active, step_count); end
    collect(1, 10, got);
    checks++; if (got != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", got); end
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    collect(1, 10, got);
    checks++; if (got != 0 || step_count !== 32'd1) begin failures++; $display("FAIL abort_pick fires=%0d count=%0d exp 0/1", got, step_count); end
  endtask

  task automatic test_lfsr_mode();
    int got;
    logic [15:0] l;
    int s;
    enable = 1'b1; mode = 1'b1; excited = '1; step_limit = 16'd0;
    apply_reset();
    l = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      s = int'(l[5:0]);
      if (s >= G) s = s - G;
      exp_q.push_back(s);
      l = lfsr_step(l);
    end
    collect(8, 40, got);
    while (exp_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL lfsr_seq missing exp=%0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o != e) begin failures++; $display("FAIL lfsr_seq got=%0d exp=%0d", o, e); end
      end
    end
    excited = '0; excited[7] = 1'b1;
    apply_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(7);
    collect(6, 30, got);
    while (exp_q.size() > 0) begin
      int e, o;
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL single_seq missing exp=%0d", e); end
      else begin
        o = obs_q.pop_front();
        if (o != e) begin failures++; $display("FAIL single_seq got=%0d exp=%0d", o, e); end
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_reset_midfire();
    int got;
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd0;
    apply_reset();
    collect(3, 20, got);
    checks++; if (got != 3) begin failures++; $display("FAIL midfire_setup got=%0d exp=3", got); end
    reset = 1'b0;
    #1;
    checks++; if (active !== 6'd30 || fire !== 1'b0 || step_count !== 32'd0) begin failures++; $display("FAIL midfire_reset active=%0d fire=%b count=%0d exp 30/0/0", active, fire, step_count); end
    @(negedge clk);
    reset = 1'b1;
    obs_q.delete();
    cyc_q.delete();
    collect(1, 10, got);
    checks++; if (got != 1 || obs_q.size() == 0 || obs_q[0] != 0) begin failures++; $display("FAIL midfire_restart fires=%0d exp first active=0", got); end
  endtask

`ifdef ASYNC_SCHED_STARVE_MON_EN
  task automatic test_starve();
    int got;
    enable = 1'b1; mode = 1'b0; excited = '1; step_limit = 16'd0;
    apply_reset();
    collect(200, 500, got);
    checks++; if (starved !== 1'b0) begin failures++; $display("FAIL starve_rr got=%b exp=0", starved); end
  endtask
`endif

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 1'b0; excited = '0; step_limit = 16'd0;
    test_reset();
    test_round_robin();
    test_sparse();
    test_deadlock();
    test_step_limit();
    test_abort();
    test_lfsr_mode();
    test_reset_midfire();
`ifdef ASYNC_SCHED_STARVE_MON_EN
    test_starve();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
